dm_ctrl: RTL and testbench

Parametrised data-memory controller for the pipelined MIPS CPU's MEM stage: word/half/byte stores with lane merge, sign- or zero-extended loads, and a request/response handshake with configurable wait states. It replaces the fixed 4096-word single-cycle data memory. Clearing is a counted multi-cycle sweep rather than a one-edge wipe. It sits between the M-stage pipeline register and the W-stage register and raises `err` on misaligned or out-of-range accesses.

---
 rtl/dm_pkg.sv | 28 ++
 rtl/dm_ldext.sv | 35 +++
 rtl/dm_ctrl.sv | 209 ++++++++++++++++++++
 tb/tb_dm_ctrl.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dm_pkg.sv
// Shared encodings for the MEM-stage data-memory controller (dm_ctrl):
// access sizes, controller states and the store byte-lane helper.
package dm_pkg;

  localparam logic [1:0] SZ_W = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_B = 2'd2;

  typedef enum logic [1:0] {
    DM_IDLE  = 2'd0,
    DM_WAIT  = 2'd1,
    DM_RESP  = 2'd2,
    DM_CLEAR = 2'd3
  } dm_state_e;

  // Byte-lane enables for an access of the given size at byte offset off.
  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
    logic [3:0] m;
    case (size)
      SZ_W:    m = 4'b1111;
      SZ_H:    m = off[1] ? 4'b1100 : 4'b0011;
      SZ_B:    m = 4'b0001 << off;
      default: m = 4'b0000;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/dm_ldext.sv
// Load lane extraction: picks the byte/half addressed by i_off out of the
// memory word and sign- or zero-extends it to 32 bits.
module dm_ldext
  import dm_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [1:0]  i_off,
  input  logic [1:0]  i_size,
  input  logic        i_sext,
  output logic [31:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = 8'h00;
    w_half = 16'h0000;
    o_data = 32'h0000_0000;
    case (i_off)
      2'd0:    w_byte = i_word[7:0];
      2'd1:    w_byte = i_word[15:8];
      2'd2:    w_byte = i_word[23:16];
      default: w_byte = i_word[31:24];
    endcase
    w_half = i_off[1] ? i_word[31:16] : i_word[15:0];
    case (i_size)
      SZ_W:    o_data = i_word;
      SZ_H:    o_data = {{16{i_sext & w_half[15]}}, w_half};
      SZ_B:    o_data = {{24{i_sext & w_byte[7]}}, w_byte};
      default: o_data = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/dm_ctrl.sv
// MEM-stage data memory: lane-merged stores, extended loads, req/response
// handshake with WAIT_CYC wait states and a counted clear sweep. Define
// DM_TRACE_EN to print every committed store.
module dm_ctrl
  import dm_pkg::*;
#(
  parameter int ADDR_W   = 12,
  parameter int WAIT_CYC = 0
) (
  input  logic        clk,
  input  logic        clr_n,
  input  logic        req,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic        sext,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [31:0] pc,
  input  logic        intreq,
  input  logic        flush,
  output logic        ready,
  output logic        rvalid,
  output logic [31:0] rdata,
  output logic        err,
  output logic        busy
);

  localparam int                DEPTH     = 2 ** ADDR_W;
  localparam bit                ZERO_WAIT = (WAIT_CYC == 0);
  localparam logic [3:0]        WAIT_LAST = (WAIT_CYC > 0) ? 4'(WAIT_CYC - 1) : 4'd0;
  localparam logic [ADDR_W-1:0] CLR_LAST  = {ADDR_W{1'b1}};
  localparam logic [ADDR_W-1:0] CLR_ZERO  = {ADDR_W{1'b0}};
  localparam logic [ADDR_W-1:0] CLR_ONE   = {{(ADDR_W-1){1'b0}}, 1'b1};

  logic [31:0]       r_mem [DEPTH];
  dm_state_e         r_state;
  dm_state_e         w_state_nxt;
  logic [3:0]        r_wait_cnt;
  logic [3:0]        w_wait_cnt_nxt;
  logic [ADDR_W-1:0] r_clr_cnt;
  logic [ADDR_W-1:0] w_clr_cnt_nxt;
  logic              r_rvalid;
  logic              r_err;
  logic [31:0]       r_rdata;
  logic              r_pend_err;
  logic [31:0]       r_pend_data;

  logic              w_accept;
  logic              w_oor;
  logic              w_fault;
  logic              w_commit;
  logic              w_clr_we;
  logic              w_rsp_now;
  logic              w_rsp_pend;
  logic [ADDR_W-1:0] w_widx;
  logic [3:0]        w_lanes;
  logic [31:0]       w_rd_word;
  logic [31:0]       w_ld_data;
  logic [31:0]       w_rsp_data;
  logic [31:0]       w_rep;
  logic [31:0]       w_bmask;
  logic [31:0]       w_merged;

  assign ready  = (r_state == DM_IDLE) & ~flush;
  assign busy   = (r_state == DM_CLEAR);
  assign rvalid = r_rvalid;
  assign rdata  = r_rdata;
  assign err    = r_err;

  assign w_accept  = req & ready;
  assign w_widx    = addr[ADDR_W+1:2];
  assign w_oor     = |(addr >> (ADDR_W + 2));
  assign w_fault   = (size == 2'd3)
                   | ((size == SZ_H) & addr[0])
                   | ((size == SZ_W) & (addr[1:0] != 2'b00))
                   | w_oor;
  assign w_rd_word = r_mem[w_widx];

  dm_ldext u_ldext (
    .i_word (w_rd_word),
    .i_off  (addr[1:0]),
    .i_size (size),
    .i_sext (sext),
    .o_data (w_ld_data)
  );

  // Stores and faults answer with zero data.
  assign w_rsp_data = (we | w_fault) ? 32'h0000_0000 : w_ld_data;

  assign w_lanes  = lane_mask(size, addr[1:0]);
  assign w_bmask  = {{8{w_lanes[3]}}, {8{w_lanes[2]}}, {8{w_lanes[1]}}, {8{w_lanes[0]}}};
  assign w_merged = (w_rd_word & ~w_bmask) | (w_rep & w_bmask);
  assign w_commit = clr_n & w_accept & we & ~w_fault & ~intreq;

  // Replicate the low bytes of the store data across all lanes.
  always_comb begin
    w_rep = wdata;
    case (size)
      SZ_H:    w_rep = {2{wdata[15:0]}};
      SZ_B:    w_rep = {4{wdata[7:0]}};
      default: w_rep = wdata;
    endcase
  end

  // Next-state, counter and response-issue decode.
  always_comb begin
    w_state_nxt    = r_state;
    w_wait_cnt_nxt = r_wait_cnt;
    w_clr_cnt_nxt  = r_clr_cnt;
    w_rsp_now      = 1'b0;
    w_rsp_pend     = 1'b0;
    w_clr_we       = 1'b0;
    case (r_state)
      DM_IDLE: begin
        if (flush) begin
          w_state_nxt   = DM_CLEAR;
          w_clr_cnt_nxt = CLR_ZERO;
        end else if (req) begin
          if (ZERO_WAIT) begin
            w_rsp_now = 1'b1;
          end else begin
            w_state_nxt    = DM_WAIT;
            w_wait_cnt_nxt = 4'd0;
          end
        end else begin
          w_state_nxt = DM_IDLE;
        end
      end
      DM_WAIT: begin
        if (r_wait_cnt == WAIT_LAST) begin
          w_state_nxt = DM_RESP;
          w_rsp_pend  = 1'b1;
        end else begin
          w_wait_cnt_nxt = r_wait_cnt + 4'd1;
        end
      end
      DM_RESP: begin
        w_state_nxt = DM_IDLE;
      end
      DM_CLEAR: begin
        w_clr_we = 1'b1;
        if (r_clr_cnt == CLR_LAST) begin
          w_state_nxt   = DM_IDLE;
          w_clr_cnt_nxt = CLR_ZERO;
        end else begin
          w_clr_cnt_nxt = r_clr_cnt + CLR_ONE;
        end
      end
      default: begin
        w_state_nxt = DM_IDLE;
      end
    endcase
  end

  // FSM state and counters.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_state    <= DM_IDLE;
      r_wait_cnt <= 4'd0;
      r_clr_cnt  <= CLR_ZERO;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_cnt_nxt;
      r_clr_cnt  <= w_clr_cnt_nxt;
    end
  end

  // Response registers; the pending copy carries the result across wait states.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_rvalid    <= 1'b0;
      r_err       <= 1'b0;
      r_rdata     <= 32'h0000_0000;
      r_pend_err  <= 1'b0;
      r_pend_data <= 32'h0000_0000;
    end else begin
      r_rvalid <= w_rsp_now | w_rsp_pend;
      if (w_rsp_now) begin
        r_rdata <= w_rsp_data;
        r_err   <= w_fault;
      end else if (w_rsp_pend) begin
        r_rdata <= r_pend_data;
        r_err   <= r_pend_err;
      end
      if (w_accept) begin
        r_pend_data <= w_rsp_data;
        r_pend_err  <= w_fault;
      end
    end
  end

  // Storage array: clear sweep or committed store, never reset.
  always_ff @(posedge clk) begin
    if (w_clr_we) begin
      r_mem[r_clr_cnt] <= 32'h0000_0000;
    end else if (w_commit) begin
      r_mem[w_widx] <= w_merged;
`ifdef DM_TRACE_EN
      $display("%d@%h: *%h <= %h", $time, pc, {addr[31:2], 2'b00}, w_merged);
`endif
    end
  end

`ifndef DM_TRACE_EN
  logic w_unused_pc;
  assign w_unused_pc = ^pc;
`endif

endmodule

// File: tb/tb_dm_ctrl.sv
// Bench for dm_ctrl: a zero-wait and a three-wait instance compared every
// cycle against a byte-addressed reference memory, plus literal spot checks.
module tb_dm_ctrl;

  localparam int ADDR_W = 12;
  localparam int DEPTH  = 4096;
  localparam int NBYTE  = 4 * DEPTH;

  logic        clk = 1'b0;
  logic        clr_n, req0, req3, we, sext, intreq, flush;
  logic [1:0]  size;
  logic [31:0] addr, wdata, pc;
  logic        ready0, rvalid0, err0, busy0;
  logic        ready3, rvalid3, err3, busy3;
  logic [31:0] rdata0, rdata3;

  dm_ctrl #(.ADDR_W(ADDR_W), .WAIT_CYC(0)) u_dut0 (
    .clk(clk), .clr_n(clr_n), .req(req0), .we(we), .size(size), .sext(sext),
    .addr(addr), .wdata(wdata), .pc(pc), .intreq(intreq), .flush(flush),
    .ready(ready0), .rvalid(rvalid0), .rdata(rdata0), .err(err0), .busy(busy0)
  );

  dm_ctrl #(.ADDR_W(ADDR_W), .WAIT_CYC(3)) u_dut3 (
    .clk(clk), .clr_n(clr_n), .req(req3), .we(we), .size(size), .sext(sext),
    .addr(addr), .wdata(wdata), .pc(pc), .intreq(intreq), .flush(flush),
    .ready(ready3), .rvalid(rvalid3), .rdata(rdata3), .err(err3), .busy(busy3)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [31:0] d;
    bit          e;
  } rsp_t;

  rsp_t        q [2][$];
  bit [7:0]    mb [2][NBYTE];
  logic [31:0] last_d [2];
  bit          last_e [2];
  int          cyc;
  int          blk3;
  int          clr_start;
  int          n_tests;
  int          n_fail;
  bit          chk_en;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", nm, cyc, act, exp);
    end
  endtask

  task automatic chk_rsp(input int i, input logic rv, input logic [31:0] rd, input logic er);
    bit exp_v;
    exp_v = (q[i].size() > 0) && (q[i][0].due == cyc);
    check(i == 0 ? "rvalid0" : "rvalid3", 32'(rv), 32'(exp_v));
    if (exp_v) begin
      last_d[i] = q[i][0].d;
      last_e[i] = q[i][0].e;
      void'(q[i].pop_front());
    end
    while ((q[i].size() > 0) && (q[i][0].due < cyc)) void'(q[i].pop_front());
    check(i == 0 ? "rdata0" : "rdata3", rd, last_d[i]);
    check(i == 0 ? "err0" : "err3", 32'(er), 32'(last_e[i]));
  endtask

  // Every-cycle comparison of both instances against the reference model.
  always @(negedge clk) begin
    if (chk_en) begin
      bit eb;
      eb = (cyc >= clr_start) && (cyc < clr_start + DEPTH);
      chk_rsp(0, rvalid0, rdata0, err0);
      chk_rsp(1, rvalid3, rdata3, err3);
      check("busy0", 32'(busy0), 32'(eb));
      check("busy3", 32'(busy3), 32'(eb));
      check("ready0", 32'(ready0), 32'(!eb && !flush));
      check("ready3", 32'(ready3), 32'(!eb && !flush && (cyc > blk3)));
    end
  end

  // Reference: byte memory, faults by alignment/range, little-endian lanes.
  task automatic model_acc(input int i, input bit w, input logic [1:0] sz, input bit sx,
                           input logic [31:0] a, input logic [31:0] wd, input bit irq);
    int          n;
    bit          f;
    logic [31:0] v;
    rsp_t        r;
    n = (sz == 2'd0) ? 4 : (sz == 2'd1) ? 2 : (sz == 2'd2) ? 1 : 0;
    if (n == 0) f = 1'b1;
    else f = (a >= 32'(NBYTE)) || ((a % 32'(n)) != 32'd0);
    v = 32'h0;
    if (!f && !w) begin
      for (int b = 0; b < n; b++) v[8*b +: 8] = mb[i][a + 32'(b)];
      if (sx && v[8*n-1]) for (int b = 8*n; b < 32; b++) v[b] = 1'b1;
    end
    if (!f && w && !irq) for (int b = 0; b < n; b++) mb[i][a + 32'(b)] = wd[8*b +: 8];
    r.due = cyc + ((i == 0) ? 0 : 3);
    r.d   = v;
    r.e   = f;
    q[i].push_back(r);
    if (i == 1) blk3 = cyc + 3;
  endtask

  task automatic step(input bit r0, input bit r3, input bit w, input logic [1:0] sz, input bit sx,
                      input logic [31:0] a, input logic [31:0] wd, input bit irq);
    req0 = r0; req3 = r3; we = w; size = sz; sext = sx;
    addr = a; wdata = wd; intreq = irq; pc = pc + 32'd4;
    @(posedge clk); #1;
    if (r0) model_acc(0, w, sz, sx, a, wd, irq);
    if (r3) model_acc(1, w, sz, sx, a, wd, irq);
  endtask

  task automatic idle(input int n);
    req0 = 1'b0; req3 = 1'b0; flush = 1'b0; intreq = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic acc(input bit w, input logic [1:0] sz, input bit sx,
                     input logic [31:0] a, input logic [31:0] wd, input bit irq);
    step(1'b1, 1'b1, w, sz, sx, a, wd, irq);
    idle(5);
  endtask

  task automatic ld_lit(input logic [1:0] sz, input bit sx, input logic [31:0] a,
                        input logic [31:0] exp_d, input bit exp_e);
    acc(1'b0, sz, sx, a, 32'h0, 1'b0);
    check("lit_rdata0", rdata0, exp_d);
    check("lit_rdata3", rdata3, exp_d);
    check("lit_err0", 32'(err0), 32'(exp_e));
    check("lit_err3", 32'(err3), 32'(exp_e));
  endtask

  task automatic st_lit(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd,
                        input bit irq, input bit exp_e);
    acc(1'b1, sz, 1'b0, a, wd, irq);
    check("st_err0", 32'(err0), 32'(exp_e));
    check("st_err3", 32'(err3), 32'(exp_e));
    check("st_rdata0", rdata0, 32'h0);
  endtask

  task automatic do_flush(input bit with_req);
    flush = 1'b1; req0 = with_req; req3 = with_req; we = 1'b0; size = 2'd0; addr = 32'h10;
    @(posedge clk); #1;
    clr_start = cyc;
    for (int b = 0; b < NBYTE; b++) begin mb[0][b] = 8'h00; mb[1][b] = 8'h00; end
    flush = 1'b0; req0 = 1'b0; req3 = 1'b0;
  endtask

  initial begin
    clr_n = 1'b0; req0 = 1'b0; req3 = 1'b0; we = 1'b0; size = 2'd0; sext = 1'b0;
    addr = 32'h0; wdata = 32'h0; pc = 32'h0040_0000; intreq = 1'b0; flush = 1'b0;
    blk3 = -1; clr_start = -100000;
    last_d[0] = 32'h0; last_d[1] = 32'h0; last_e[0] = 1'b0; last_e[1] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_rvalid", 32'({rvalid0, rvalid3}), 32'h0);
    check("rst_err", 32'({err0, err3}), 32'h0);
    check("rst_busy", 32'({busy0, busy3}), 32'h0);
    check("rst_rdata0", rdata0, 32'h0);
    check("rst_rdata3", rdata3, 32'h0);
    clr_n = 1'b1;
    check("rst_ready", 32'({ready0, ready3}), 32'h3);
    chk_en = 1'b1;

    do_flush(1'b0);
    idle(DEPTH + 4);

    st_lit(2'd0, 32'h10, 32'h1234_5678, 1'b0, 1'b0);
    ld_lit(2'd2, 1'b1, 32'h11, 32'h0000_0056, 1'b0);
    ld_lit(2'd1, 1'b0, 32'h12, 32'h0000_1234, 1'b0);
    ld_lit(2'd1, 1'b1, 32'h10, 32'h0000_5678, 1'b0);
    ld_lit(2'd2, 1'b1, 32'h13, 32'h0000_0012, 1'b0);
    st_lit(2'd2, 32'h23, 32'hABCD_EFF0, 1'b0, 1'b0);
    ld_lit(2'd0, 1'b0, 32'h20, 32'hF000_0000, 1'b0);
    ld_lit(2'd2, 1'b1, 32'h23, 32'hFFFF_FFF0, 1'b0);

    ld_lit(2'd0, 1'b0, 32'h2, 32'h0, 1'b1);
    ld_lit(2'd0, 1'b0, 32'h4000, 32'h0, 1'b1);
    st_lit(2'd0, 32'h12, 32'hDEAD_BEEF, 1'b0, 1'b1);
    st_lit(2'd3, 32'h10, 32'hDEAD_BEEF, 1'b0, 1'b1);
    st_lit(2'd1, 32'h11, 32'hDEAD_BEEF, 1'b0, 1'b1);
    st_lit(2'd2, 32'h4011, 32'hDEAD_BEEF, 1'b0, 1'b1);
    st_lit(2'd0, 32'h10, 32'h0000_0055, 1'b1, 1'b0);
    ld_lit(2'd0, 1'b0, 32'h10, 32'h1234_5678, 1'b0);

    st_lit(2'd1, 32'h22, 32'h1234_BEEF, 1'b0, 1'b0);
    ld_lit(2'd1, 1'b1, 32'h22, 32'hFFFF_BEEF, 1'b0);
    ld_lit(2'd2, 1'b0, 32'h20, 32'h0, 1'b0);
    ld_lit(2'd0, 1'b0, 32'h20, 32'hBEEF_0000, 1'b0);

    // Three-wait instance: ready low for four cycles, rvalid on the fourth.
    step(1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 32'h10, 32'h0, 1'b0);
    req3 = 1'b0;
    check("w3_ready_t1", 32'(ready3), 32'h0);
    idle(3);
    check("w3_rvalid_t4", 32'(rvalid3), 32'h1);
    check("w3_ready_t4", 32'(ready3), 32'h0);
    check("w3_rdata_t4", rdata3, 32'h1234_5678);
    idle(1);
    check("w3_ready_t5", 32'(ready3), 32'h1);
    check("w3_rvalid_t5", 32'(rvalid3), 32'h0);

    // Zero-wait instance: back-to-back store then loads of the same word.
    step(1'b1, 1'b0, 1'b1, 2'd0, 1'b0, 32'h40, 32'hCAFE_F00D, 1'b0);
    step(1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 32'h40, 32'h0, 1'b0);
    check("b2b_word", rdata0, 32'hCAFE_F00D);
    step(1'b1, 1'b0, 1'b0, 2'd2, 1'b0, 32'h41, 32'h0, 1'b0);
    check("b2b_byte", rdata0, 32'h0000_00F0);
    idle(3);

    do_flush(1'b1);
    check("flush_busy", 32'({busy0, busy3}), 32'h3);
    check("flush_ready", 32'({ready0, ready3}), 32'h0);
    check("flush_noacc", 32'({rvalid0, rvalid3}), 32'h0);
    idle(2000);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    idle(2100);
    check("clear_done", 32'({busy0, busy3}), 32'h0);
    ld_lit(2'd0, 1'b0, 32'h10, 32'h0, 1'b0);
    ld_lit(2'd0, 1'b0, 32'h20, 32'h0, 1'b0);

    do_flush(1'b0);
    idle(100);
    check("sweep_busy", 32'({busy0, busy3}), 32'h3);
    chk_en = 1'b0;
    clr_n = 1'b0;
    #1;
    check("abort_busy", 32'({busy0, busy3}), 32'h0);
    idle(2);
    clr_n = 1'b1;
    q[0].delete(); q[1].delete();
    last_d[0] = 32'h0; last_d[1] = 32'h0; last_e[0] = 1'b0; last_e[1] = 1'b0;
    clr_start = -100000; blk3 = -1;
    chk_en = 1'b1;
    idle(3);
    check("abort_ready", 32'({ready0, ready3}), 32'h3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
